dds_phase_accum: RTL and testbench

Phase-accumulator front end of the DDS oscillator. It sits directly upstream of `sine_lookup` and feeds it the `{neg, inv, addr, cntr}` phase word. On each sample-rate strobe it adds a frequency tuning word (FTW) to a wide accumulator and registers the top bits as the lookup word. FTW updates arrive over a single-entry valid/ready mailbox and take effect only on sample boundaries, so frequency changes never glitch mid-sample.

---
 rtl/dds_pkg.sv | 22 ++
 rtl/dds_ftw_mailbox.sv | 31 +++
 rtl/dds_phase_accum.sv | 104 ++++++++++
 tb/tb_dds_phase_accum.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared DDS definitions: default widths and the phase-word layout that
// the phase accumulator hands to sine_lookup.
package dds_pkg;

    localparam int DDS_ACC_WDTH  = 32;
    localparam int DDS_ADDR_WDTH = 12;
    localparam int DDS_CNTR_WDTH = 4;
    localparam int DDS_OUT_WDTH  = DDS_ADDR_WDTH + DDS_CNTR_WDTH;

    // Flat phase word as carried on the sine_lookup port.
    typedef logic [DDS_OUT_WDTH-1:0] phase_word_t;

    // Field view of the same word: quadrant bits on top, table address in
    // the middle, interpolation counter at the bottom.
    typedef struct packed {
        logic                       neg;
        logic                       inv;
        logic [DDS_ADDR_WDTH-3:0]   addr;
        logic [DDS_CNTR_WDTH-1:0]   cntr;
    } phase_fields_t;

endpackage

// File: rtl/dds_ftw_mailbox.sv
// Single-entry valid/ready holding register for frequency tuning words.
// A word sits here until the accumulator consumes it on a sample boundary.
module dds_ftw_mailbox #(
    parameter int WDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WDTH-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            consume,
    output logic [WDTH-1:0] held_data,
    output logic            held_flag
);

    assign in_ready = !held_flag && !rst;

    // Capture an offered word when empty; release it when the accumulator consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_flag <= 1'b0;
            held_data <= '0;
        end else if (in_valid && in_ready) begin
            held_flag <= 1'b1;
            held_data <= in_data;
        end else if (consume) begin
            held_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: steps a wide accumulator by the active tuning word
// on every enabled sample tick and registers its top bits as the lookup word.
// Tuning-word changes and phase restarts only take effect on tick boundaries.
module dds_phase_accum
    import dds_pkg::*;
#(
    parameter  int ACC_WDTH  = DDS_ACC_WDTH,
    parameter  int ADDR_WDTH = DDS_ADDR_WDTH,
    parameter  int CNTR_WDTH = DDS_CNTR_WDTH,
    localparam int OUT_WDTH  = ADDR_WDTH + CNTR_WDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic                enable,
    input  logic [ACC_WDTH-1:0] ftw_data,
    input  logic                ftw_valid,
    output logic                ftw_ready,
    input  logic                phase_sync,
    output logic [OUT_WDTH-1:0] sine_lookup,
    output logic                lookup_valid,
    output logic                wrap
);

    generate
        if (ACC_WDTH < OUT_WDTH) begin : g_width_check
            $error("dds_phase_accum: ACC_WDTH must be at least ADDR_WDTH+CNTR_WDTH");
        end
    endgenerate

    logic                eff_tick;
    logic                consume;
    logic [ACC_WDTH-1:0] acc;
    logic [ACC_WDTH-1:0] active_ftw;
    logic [ACC_WDTH-1:0] pend_ftw;
    logic                pend_flag;
    logic                sync_flag;
    logic [ACC_WDTH-1:0] inc;
    logic [ACC_WDTH:0]   sum;

    assign eff_tick = sample_tick && enable;
    assign consume  = eff_tick && pend_flag;

    dds_ftw_mailbox #(
        .WDTH(ACC_WDTH)
    ) u_mailbox (
        .clk       (clk),
        .rst       (rst),
        .in_data   (ftw_data),
        .in_valid  (ftw_valid),
        .in_ready  (ftw_ready),
        .consume   (consume),
        .held_data (pend_ftw),
        .held_flag (pend_flag)
    );

    // A pending word is applied on the same tick that promotes it, so the increment prefers it.
    always_comb begin
        inc = pend_flag ? pend_ftw : active_ftw;
        sum = {1'b0, acc} + {1'b0, inc};
    end

    // Promote the pending tuning word to active on the tick that consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_ftw <= '0;
        end else if (consume) begin
            active_ftw <= pend_ftw;
        end
    end

    // Sync requests latch until a tick services them; a request arriving with a tick waits for the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_flag <= 1'b0;
        end else begin
            sync_flag <= phase_sync || (sync_flag && !eff_tick);
        end
    end

    // Advance (or restart) the accumulator on each effective tick and register the lookup word.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            sine_lookup  <= '0;
            lookup_valid <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            lookup_valid <= eff_tick;
            wrap         <= 1'b0;
            if (eff_tick) begin
                if (sync_flag) begin
                    acc         <= '0;
                    sine_lookup <= '0;
                end else begin
                    acc         <= sum[ACC_WDTH-1:0];
                    sine_lookup <= sum[ACC_WDTH-1 -: OUT_WDTH];
                    wrap        <= sum[ACC_WDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_accum.sv
// Testbench for dds_phase_accum: table-driven sweep, hand-written corner
// sequences, and a randomized run against a behavioural model.
module tb_dds_phase_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic        enable;
    logic [31:0] ftw_data;
    logic        ftw_valid;
    logic        ftw_ready;
    logic        phase_sync;
    logic [15:0] sine_lookup;
    logic        lookup_valid;
    logic        wrap;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state
    logic [31:0] mAcc, mActive, mPend;
    bit          mPendFull, mSync, mValid, mWrap, mAccepted;
    logic [15:0] mLookup;

    typedef struct {
        bit          tick;
        bit          valid;
        logic [31:0] data;
        logic [15:0] expLookup;
        bit          expValid;
        bit          expWrap;
        bit          expReady;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    dds_phase_accum dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .enable       (enable),
        .ftw_data     (ftw_data),
        .ftw_valid    (ftw_valid),
        .ftw_ready    (ftw_ready),
        .phase_sync   (phase_sync),
        .sine_lookup  (sine_lookup),
        .lookup_valid (lookup_valid),
        .wrap         (wrap)
    );

    // Model one clock edge from the current inputs: phase is a number modulo 2^32.
    function automatic void modelStep();
        longint unsigned total;
        logic [31:0]     step;
        bit              tickNow;
        tickNow   = sample_tick && enable;
        mAccepted = 1'b0;
        if (rst) begin
            mAcc = '0; mActive = '0; mPend = '0;
            mPendFull = 0; mSync = 0; mValid = 0; mWrap = 0;
            mLookup = '0;
        end else begin
            mAccepted = ftw_valid && !mPendFull;
            mValid    = tickNow;
            mWrap     = 0;
            if (tickNow) begin
                step = mPendFull ? mPend : mActive;
                if (mPendFull) begin
                    mActive   = mPend;
                    mPendFull = 0;
                end
                if (mSync) begin
                    mAcc  = '0;
                    mSync = 0;
                end else begin
                    total = 64'(mAcc) + 64'(step);
                    mWrap = (total >= 64'h1_0000_0000);
                    mAcc  = 32'(total % 64'h1_0000_0000);
                end
                mLookup = mAcc[31:16];
            end
            if (phase_sync) mSync = 1;
            if (mAccepted) begin
                mPend     = ftw_data;
                mPendFull = 1;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit tick, input bit en, input bit valid,
                                 input logic [31:0] data, input bit sync);
        rst         = r;
        sample_tick = tick;
        enable      = en;
        ftw_valid   = valid;
        ftw_data    = data;
        phase_sync  = sync;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("model_lookup", 32'(sine_lookup), 32'(mLookup));
        checkOutput("model_valid", 32'(lookup_valid), 32'(mValid));
        checkOutput("model_wrap", 32'(wrap), 32'(mWrap));
        checkOutput("model_ready", 32'(ftw_ready), 32'(!mPendFull && !r));
    endtask

    task automatic idle();
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
    endtask

    task automatic tick();
        applyStimulus(0, 1, 1, 0, 32'h0, 0);
    endtask

    task automatic offer(input logic [31:0] data);
        applyStimulus(0, 0, 1, 1, data, 0);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 1, 0, 32'h0, 0);
        applyStimulus(1, 0, 1, 0, 32'h0, 0);
    endtask

    task automatic checkLookup(input string name, input logic [15:0] expLookup, input bit expValid,
                               input bit expWrap);
        checkOutput({name, "_lookup"}, 32'(sine_lookup), 32'(expLookup));
        checkOutput({name, "_valid"}, 32'(lookup_valid), 32'(expValid));
        checkOutput({name, "_wrap"}, 32'(wrap), 32'(expWrap));
    endtask

    initial begin
        vec_t        v;
        int          wrapCount;
        bit          holdValid;
        bit          rRst, rTick, rEn, rValid, rSync;
        logic [31:0] rData;

        rst = 1'b1; sample_tick = 0; enable = 0; ftw_valid = 0; ftw_data = 0; phase_sync = 0;

        // ---------------- Reset state ----------------
        doReset();
        checkLookup("reset", 16'h0000, 0, 0);
        checkOutput("reset_ready", 32'(ftw_ready), 32'd0);
        idle();
        checkOutput("ready_after_reset", 32'(ftw_ready), 32'd1);

        // ---------------- Basic sweep (table) ----------------
        v = '{tick: 0, valid: 1, data: 32'h1000_0000, expLookup: 16'h0, expValid: 0, expWrap: 0, expReady: 0};
        vecs.push_back(v);
        for (int i = 1; i <= 16; i++) begin
            v = '{tick: 1, valid: 0, data: 32'h0, expLookup: 16'(i * 4096), expValid: 1,
                  expWrap: (i == 16), expReady: 1};
            vecs.push_back(v);
            v = '{tick: 0, valid: 0, data: 32'h0, expLookup: 16'(i * 4096), expValid: 0,
                  expWrap: 0, expReady: 1};
            vecs.push_back(v);
        end
        foreach (vecs[k]) begin
            applyStimulus(0, vecs[k].tick, 1, vecs[k].valid, vecs[k].data, 0);
            checkLookup("sweep", vecs[k].expLookup, vecs[k].expValid, vecs[k].expWrap);
            checkOutput("sweep_ready", 32'(ftw_ready), 32'(vecs[k].expReady));
        end

        // ---------------- 1 kHz at 48 kHz ----------------
        // 48 steps of 0x0555_5555 land on 0xFFFF_FFF0, just short of the
        // wrap; the 49th step completes the cycle.
        doReset();
        offer(32'h0555_5555);
        wrapCount = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (wrap) wrapCount++;
            idle();
        end
        checkOutput("khz_final_lookup", 32'(sine_lookup), 32'h0000_FFFF);
        checkOutput("khz_wraps_48", 32'(wrapCount), 32'd0);
        tick();
        if (wrap) wrapCount++;
        checkLookup("khz_tick49", 16'h0555, 1, 1);
        checkOutput("khz_wraps_49", 32'(wrapCount), 32'd1);

        // ---------------- Accept with tick ----------------
        doReset();
        offer(32'h0100_0000);
        tick();
        checkLookup("awt_first", 16'h0100, 1, 0);
        idle();
        applyStimulus(0, 1, 1, 1, 32'h0200_0000, 0);
        checkLookup("awt_old_inc", 16'h0200, 1, 0);
        checkOutput("awt_ready_low", 32'(ftw_ready), 32'd0);
        idle();
        checkOutput("awt_ready_still_low", 32'(ftw_ready), 32'd0);
        tick();
        checkLookup("awt_new_inc", 16'h0400, 1, 0);
        checkOutput("awt_ready_back", 32'(ftw_ready), 32'd1);

        // ---------------- Sync restart ----------------
        applyStimulus(0, 0, 1, 0, 32'h0, 1);
        applyStimulus(0, 0, 1, 0, 32'h0, 1);
        idle();
        tick();
        checkLookup("sync_restart", 16'h0000, 1, 0);
        tick();
        checkLookup("sync_resume", 16'h0200, 1, 0);
        applyStimulus(0, 1, 1, 0, 32'h0, 1);
        checkLookup("sync_with_tick", 16'h0400, 1, 0);
        tick();
        checkLookup("sync_deferred", 16'h0000, 1, 0);
        tick();
        checkLookup("sync_deferred_resume", 16'h0200, 1, 0);
        // Pending word and pending sync serviced by the same tick
        applyStimulus(0, 0, 1, 1, 32'h0300_0000, 1);
        tick();
        checkLookup("sync_ftw_restart", 16'h0000, 1, 0);
        tick();
        checkLookup("sync_ftw_new_inc", 16'h0300, 1, 0);

        // ---------------- Enable low ----------------
        offer(32'h0010_0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 32'h0, 0);
            checkLookup("enlow_hold", 16'h0300, 0, 0);
            checkOutput("enlow_ready", 32'(ftw_ready), 32'd0);
            idle();
        end
        tick();
        checkLookup("enlow_reenable", 16'h0310, 1, 0);
        checkOutput("enlow_ready_back", 32'(ftw_ready), 32'd1);

        // ---------------- Reset mid-run ----------------
        applyStimulus(0, 0, 1, 1, 32'h0400_0000, 1);
        applyStimulus(1, 0, 1, 0, 32'h0, 0);
        checkLookup("midrst", 16'h0000, 0, 0);
        checkOutput("midrst_ready", 32'(ftw_ready), 32'd0);
        idle();
        checkOutput("midrst_ready_after", 32'(ftw_ready), 32'd1);
        tick();
        checkLookup("midrst_tick1", 16'h0000, 1, 0);
        tick();
        checkLookup("midrst_tick2", 16'h0000, 1, 0);
        offer(32'h0800_0000);
        tick();
        checkLookup("midrst_newftw", 16'h0800, 1, 0);

        // ---------------- Randomized run against the model ----------------
        doReset();
        holdValid = 0;
        rData     = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            rRst  = ($urandom_range(0, 199) == 0);
            rTick = ($urandom_range(0, 2) == 0);
            rEn   = ($urandom_range(0, 7) != 0);
            rSync = ($urandom_range(0, 15) == 0);
            if (holdValid) begin
                rValid = 1;
            end else begin
                rValid = ($urandom_range(0, 3) == 0);
                rData  = $urandom;
            end
            applyStimulus(rRst, rTick, rEn, rValid, rData, rSync);
            holdValid = rValid && !mAccepted && !rRst;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
